// File: rtl/aes_key_schedule_seq_if.sv
// Word stream from the AES key-schedule engine to its consumer.
// The master drives the schedule words, and the slave accepts them with kw_ready.
interface aes_key_schedule_seq_if #(
  parameter int IDX_W = 6
);
  logic             kw_valid;
  logic             kw_ready;
  logic [31:0]      kw_data;
  logic [IDX_W-1:0] kw_idx;
  logic             kw_last;

  modport master (
    output kw_valid,
    output kw_data,
    output kw_idx,
    output kw_last,
    input  kw_ready
  );

  modport slave (
    input  kw_valid,
    input  kw_data,
    input  kw_idx,
    input  kw_last,
    output kw_ready
  );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key-schedule engine.
// After a start pulse it streams w[0..Nw-1] one word per handshake.
// An Nk-word sliding window holds w[k..k+Nk-1] while w[k] is on the bus.
// Each handshake retires the oldest slot, and the word w[k+Nk] is generated
// from the oldest slot (w[i-Nk]) and the newest slot (w[i-1]).
module aes_key_schedule_seq #(
  parameter int NK_MAX = 8,
  parameter int IDX_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            key_size,
  input  logic [32*NK_MAX-1:0]  key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  aes_key_schedule_seq_if.master kw
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // AES S-box. S(0x00) sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {~b, 3'b000};
    return SBOX[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t           state_r, state_next;
  logic [31:0]      win_r    [NK_MAX];
  logic [31:0]      win_next [NK_MAX];
  logic [3:0]       nk_r, nk_next;
  logic [2:0]       pos_r, pos_next;
  logic [7:0]       rcon_r, rcon_next;
  logic [IDX_W-1:0] idx_r, idx_next;
  logic [IDX_W-1:0] last_idx_r, last_idx_next;
  logic             valid_r, valid_next;
  logic             last_r, last_next;
  logic             busy_r, busy_next;
  logic             done_r, done_next;
  logic             err_r, err_next;

  logic [3:0]       req_nk_s;
  logic [IDX_W-1:0] req_last_s;
  logic             req_legal_s;
  logic             hs_s;
  logic [31:0]      newest_s;
  logic [31:0]      sub_in_s;
  logic [31:0]      sub_out_s;
  logic [31:0]      t_s;
  logic [31:0]      gen_word_s;

  assign hs_s = valid_r & kw.kw_ready;

  // Decode the requested key size into Nk and the last word index.
  always_comb begin
    req_nk_s   = 4'd0;
    req_last_s = '0;
    case (key_size)
      2'd0: begin
        req_nk_s   = 4'd4;
        req_last_s = IDX_W'(6'd43);
      end
      2'd1: begin
        req_nk_s   = 4'd6;
        req_last_s = IDX_W'(6'd51);
      end
      2'd2: begin
        req_nk_s   = 4'd8;
        req_last_s = IDX_W'(6'd59);
      end
      default: begin
        req_nk_s   = 4'd0;
        req_last_s = '0;
      end
    endcase
    req_legal_s = (req_nk_s != 4'd0) && (req_nk_s <= 4'(NK_MAX));
  end

  // Generate w[i] from w[i-1] (the newest slot) and w[i-Nk] (the oldest slot) using the shared S-box.
  always_comb begin
    newest_s = win_r[0];
    for (int j = 0; j < NK_MAX; j++) begin
      if (4'(j) == nk_r - 4'd1) begin
        newest_s = win_r[j];
      end else begin
        newest_s = newest_s;
      end
    end
    if (pos_r == 3'd0) begin
      sub_in_s = {newest_s[23:0], newest_s[31:24]};
    end else begin
      sub_in_s = newest_s;
    end
    sub_out_s = {sbox(sub_in_s[31:24]), sbox(sub_in_s[23:16]),
                 sbox(sub_in_s[15:8]),  sbox(sub_in_s[7:0])};
    if (pos_r == 3'd0) begin
      t_s = sub_out_s ^ {rcon_r, 24'h000000};
    end else if ((nk_r == 4'd8) && (pos_r == 3'd4)) begin
      t_s = sub_out_s;
    end else begin
      t_s = newest_s;
    end
    gen_word_s = win_r[0] ^ t_s;
  end

  // Compute the next state, the window update, and the next output register values.
  always_comb begin
    state_next    = state_r;
    win_next      = win_r;
    nk_next       = nk_r;
    pos_next      = pos_r;
    rcon_next     = rcon_r;
    idx_next      = idx_r;
    last_idx_next = last_idx_r;
    valid_next    = valid_r;
    last_next     = last_r;
    busy_next     = busy_r;
    done_next     = 1'b0;
    err_next      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && req_legal_s) begin
          for (int j = 0; j < NK_MAX; j++) begin
            win_next[j] = key_in[32*j +: 32];
          end
          nk_next       = req_nk_s;
          pos_next      = 3'd0;
          rcon_next     = 8'h01;
          idx_next      = '0;
          last_idx_next = req_last_s;
          valid_next    = 1'b1;
          last_next     = 1'b0;
          busy_next     = 1'b1;
          state_next    = RUN;
        end else if (start) begin
          err_next = 1'b1;
        end else begin
          err_next = 1'b0;
        end
      end
      RUN: begin
        if (hs_s && last_r) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (hs_s) begin
          // Retire the oldest slot. The freshly generated word enters slot Nk-1.
          for (int j = 0; j < NK_MAX; j++) begin
            if (4'(j) == nk_r - 4'd1) begin
              win_next[j] = gen_word_s;
            end else begin
              win_next[j] = win_r[(j + 1) % NK_MAX];
            end
          end
          idx_next  = idx_r + IDX_W'(1'b1);
          last_next = ((idx_r + IDX_W'(1'b1)) == last_idx_r);
          if ({1'b0, pos_r} == nk_r - 4'd1) begin
            pos_next = 3'd0;
          end else begin
            pos_next = pos_r + 3'd1;
          end
          if (pos_r == 3'd0) begin
            rcon_next = xtime(rcon_r);
          end else begin
            rcon_next = rcon_r;
          end
        end else begin
          valid_next = valid_r;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Register the FSM state, the window, and all outputs. The asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      for (int j = 0; j < NK_MAX; j++) begin
        win_r[j] <= 32'h00000000;
      end
      nk_r       <= 4'd0;
      pos_r      <= 3'd0;
      rcon_r     <= 8'h00;
      idx_r      <= '0;
      last_idx_r <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_next;
      for (int j = 0; j < NK_MAX; j++) begin
        win_r[j] <= win_next[j];
      end
      nk_r       <= nk_next;
      pos_r      <= pos_next;
      rcon_r     <= rcon_next;
      idx_r      <= idx_next;
      last_idx_r <= last_idx_next;
      valid_r    <= valid_next;
      last_r     <= last_next;
      busy_r     <= busy_next;
      done_r     <= done_next;
      err_r      <= err_next;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign kw.kw_valid = valid_r;
  assign kw.kw_data  = win_r[0];
  assign kw.kw_idx   = idx_r;
  assign kw.kw_last  = last_r;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Testbench for aes_key_schedule_seq. It applies directed FIPS-197 key vectors
// and checks every streamed word against an independent key-expansion model.
// The model builds its S-box from GF(2^8) inverses.
module tb_aes_key_schedule_seq;

  typedef struct {
    logic [1:0]   ks;
    logic [255:0] key;
    int           nk;
    int           nw;
    int           ia;
    logic [31:0]  wa;
    int           ib;
    logic [31:0]  wb;
    int           stall_pct;
    int           mid_start;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_size;
  logic [255:0] key_in;
  logic         busy, done, err;
  logic         start4;
  logic [1:0]   key_size4;
  logic [127:0] key_in4;
  logic         busy4, done4, err4;

  int tests;
  int fails;

  logic [7:0]  sbox_m   [256];
  logic [7:0]  rcon_tab [11];
  logic [31:0] model_w  [60];
  logic [31:0] rx_w     [60];
  vec_t        vecs     [5];

  aes_key_schedule_seq_if #(.IDX_W(6)) kw ();
  aes_key_schedule_seq_if #(.IDX_W(6)) kw4 ();

  aes_key_schedule_seq #(.NK_MAX(8), .IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_size(key_size), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .kw(kw.master)
  );

  aes_key_schedule_seq #(.NK_MAX(4), .IDX_W(6)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key_size(key_size4), .key_in(key_in4),
    .busy(busy4), .done(done4), .err(err4), .kw(kw4.master)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  task automatic compute_model(input vec_t v);
    logic [31:0] t;
    for (int i = 0; i < v.nk; i++) model_w[i] = v.key[32*i +: 32];
    for (int i = v.nk; i < v.nw; i++) begin
      t = model_w[i-1];
      if (i % v.nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i / v.nk], 24'h000000};
      else if (v.nk == 8 && i % v.nk == 4) t = subw(t);
      model_w[i] = model_w[i - v.nk] ^ t;
    end
  endtask

  task automatic begin_run(input vec_t v);
    key_size = v.ks;
    key_in = v.key;
    start = 1'b1;
    kw.kw_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key_in = ~v.key;
  endtask

  // Streams one run starting from the cycle after the accepting edge. It returns at the
  // negedge where done is observed, or where kw_idx reaches abort_idx.
  task automatic stream_run(input vec_t v, input int abort_idx);
    int edges, exp_k, stalls, gaps, err_seen;
    logic rdy, prev_stall, fin;
    logic [31:0] pd;
    logic [5:0] pi;
    edges = 0; exp_k = 0; stalls = 0; gaps = 0; err_seen = 0;
    prev_stall = 1'b0; fin = 1'b0; pd = 32'h0; pi = 6'h0;
    while (!fin) begin
      @(negedge clk);
      if (err) err_seen++;
      if (v.mid_start != 0 && edges == 10) begin
        start = 1'b1; key_size = 2'd3;
      end else if (v.mid_start != 0 && edges == 11) begin
        start = 1'b0;
      end
      if (done) begin
        fin = 1'b1;
        check("done_latency", 64'(edges), 64'(v.nw + stalls));
        check("word_count", 64'(exp_k), 64'(v.nw));
      end else if (abort_idx >= 0 && kw.kw_valid && kw.kw_idx == 6'(abort_idx)) begin
        fin = 1'b1;
      end else if (edges > 400) begin
        fin = 1'b1;
        check("timeout_no_done", 64'(edges), 64'(v.nw + stalls));
      end else begin
        if (!kw.kw_valid || !busy) gaps++;
        if (prev_stall) begin
          check("stall_data", 64'(kw.kw_data), 64'(pd));
          check("stall_idx", 64'(kw.kw_idx), 64'(pi));
        end
        rdy = (v.stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= v.stall_pct);
        kw.kw_ready = rdy;
        if (kw.kw_valid && rdy && exp_k < 60) begin
          check("word", 64'({kw.kw_idx, kw.kw_last, kw.kw_data}),
                64'({6'(exp_k), (exp_k == v.nw - 1), model_w[exp_k]}));
          rx_w[exp_k] = kw.kw_data;
          exp_k++;
        end
        if (kw.kw_valid && !rdy) stalls++;
        prev_stall = kw.kw_valid && !rdy;
        pd = kw.kw_data;
        pi = kw.kw_idx;
        @(posedge clk);
        edges++;
      end
    end
    check("no_gaps", 64'(gaps), 64'd0);
    check("no_err_in_run", 64'(err_seen), 64'd0);
  endtask

  task automatic spot(input vec_t v);
    check("spot_a", 64'(rx_w[v.ia]), 64'(v.wa));
    check("spot_b", 64'(rx_w[v.ib]), 64'(v.wb));
  endtask

  task automatic run_vec(input vec_t v, input int abort_idx);
    compute_model(v);
    @(negedge clk);
    begin_run(v);
    stream_run(v, abort_idx);
    if (abort_idx < 0) spot(v);
  endtask

  task automatic post_done_check();
    @(negedge clk);
    check("done_one_cycle", 64'({done, busy, kw.kw_valid}), 64'd0);
  endtask

  initial begin
    tests = 0; fails = 0;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; key_size = 2'd0; key_in = '0;
    start4 = 1'b0; key_size4 = 2'd0; key_in4 = '0;
    kw.kw_ready = 1'b0; kw4.kw_ready = 1'b1;
    rcon_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    vecs[0] = '{2'd0, {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516},
                4, 44, 4, 32'ha0fafe17, 43, 32'hb6630ca6, 0, 0};
    vecs[1] = '{2'd1, {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b,
                32'hda0e6452, 32'h8e73b0f7}, 6, 52, 6, 32'hfe0c91f7, 51, 32'h01002202, 0, 0};
    vecs[2] = '{2'd2, {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07, 32'h857d7781,
                32'h2b73aef0, 32'h15ca71be, 32'h603deb10}, 8, 60, 8, 32'h9ba35411, 59, 32'h706c631e, 0, 0};
    vecs[3] = vecs[0];
    vecs[3].stall_pct = 30;
    vecs[4] = vecs[2];
    vecs[4].stall_pct = 30;
    vecs[4].mid_start = 1;
    build_sbox();

    // Reset state is checked while reset is held and again just after it is released.
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy, done, err, kw.kw_valid, kw.kw_last, kw.kw_idx, kw.kw_data}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", 64'({busy, done, err, kw.kw_valid, kw.kw_last, kw.kw_idx}), 64'd0);

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], -1);
      post_done_check();
    end

    // Illegal key_size 3
    @(negedge clk);
    key_size = 2'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("illegal_err", 64'({err, busy, kw.kw_valid}), 64'b100);
    @(negedge clk);
    check("illegal_err_once", 64'({err, busy, kw.kw_valid}), 64'b000);

    // AES-256 on an NK_MAX=4 instance is rejected, but AES-128 is accepted.
    key_size4 = 2'd2; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    check("nkmax4_err", 64'({err4, busy4, kw4.kw_valid}), 64'b100);
    @(negedge clk);
    check("nkmax4_err_once", 64'({err4, busy4, kw4.kw_valid}), 64'b000);
    key_size4 = 2'd0; key_in4 = vecs[0].key[127:0]; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    check("nkmax4_legal", 64'({busy4, kw4.kw_valid, kw4.kw_idx, kw4.kw_data}), 64'({2'b11, 6'd0, 32'h2b7e1516}));

    // Reset in the middle of a run, at index 20
    run_vec(vecs[0], 20);
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({busy, done, err, kw.kw_valid, kw.kw_last, kw.kw_idx, kw.kw_data}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_abort", 64'({done, busy, kw.kw_valid}), 64'd0);
    run_vec(vecs[0], -1);
    post_done_check();

    // Back-to-back: a start issued in the done cycle begins the next run
    run_vec(vecs[0], -1);
    compute_model(vecs[1]);
    begin_run(vecs[1]);
    stream_run(vecs[1], -1);
    spot(vecs[1]);
    post_done_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
